// File: rtl/ae_pkg.sv
// Shared definitions for the autoencoder datapath: Q3.16 constants, frame geometry
// and the serializer state encoding.
package ae_pkg;

   localparam int DATA_W = 20;
   localparam int N_PIX  = 9;
   localparam int IDX_W  = 4;

   localparam logic signed [DATA_W-1:0] ZERO_Q16 = 20'sh00000;
   localparam logic signed [DATA_W-1:0] ONE_Q16  = 20'sh10000;
   localparam logic signed [DATA_W-1:0] HALF_Q16 = 20'sh08000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/recon_serializer_if.sv
// Per-pixel probability stream carried from the serializer to its consumer.
interface recon_serializer_if;
   import ae_pkg::*;

   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_bit;
   logic [IDX_W-1:0]  m_index;
   logic              m_last;

   modport master (
      output m_valid,
      input  m_ready,
      output m_data,
      output m_bit,
      output m_index,
      output m_last
   );

   modport slave (
      input  m_valid,
      output m_ready,
      input  m_data,
      input  m_bit,
      input  m_index,
      input  m_last
   );

endinterface

// File: rtl/prob_clamp.sv
// Combinational clamp of a signed Q3.16 probability into [0, 1.0] and its
// decision against the threshold.
module prob_clamp
   import ae_pkg::*;
#(
   parameter logic signed [DATA_W-1:0] THRESH = HALF_Q16
) (
   input  logic signed [DATA_W-1:0] prob,
   output logic signed [DATA_W-1:0] clamped,
   output logic                     bit_out
);

   always_comb begin
      if (prob < ZERO_Q16) begin
         clamped = ZERO_Q16;
      end else if (prob > ONE_Q16) begin
         clamped = ONE_Q16;
      end else begin
         clamped = prob;
      end
      bit_out = (clamped >= THRESH);
   end

endmodule

// File: rtl/recon_serializer.sv
// Snapshots a frame of sigmoid outputs, streams the clamped probabilities one
// pixel per beat and accumulates the reconstruction Hamming error.
module recon_serializer
   import ae_pkg::*;
#(
   parameter logic signed [DATA_W-1:0] THRESH = HALF_Q16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [N_PIX-1:0]        x_in,
   input  logic [N_PIX*DATA_W-1:0] prob_in,
   output logic                    busy,
   recon_serializer_if.master      m,
   output logic [N_PIX-1:0]        recon,
   output logic [IDX_W-1:0]        err_count,
   output logic                    done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);

   state_t                   state;
   state_t                   state_next;
   logic [IDX_W-1:0]         idx;
   logic [N_PIX-1:0]         x_cap;
   logic signed [DATA_W-1:0] prob_cap [N_PIX];
   logic signed [DATA_W-1:0] cur_raw;
   logic signed [DATA_W-1:0] cur_clamp;
   logic                     cur_bit;
   logic                     in_send;
   logic                     at_last;
   logic                     beat_fire;

   assign cur_raw   = prob_cap[idx];
   assign in_send   = (state == SEND);
   assign at_last   = (idx == LAST_IDX);
   assign beat_fire = in_send && m.m_ready;

   prob_clamp #(
      .THRESH (THRESH)
   ) u_clamp (
      .prob    (cur_raw),
      .clamped (cur_clamp),
      .bit_out (cur_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Stream outputs are a function of state and captured data only, so m_valid
   // never depends on m_ready and the beat holds steady through a stall.
   always_comb begin
      state_next  = state;
      busy        = 1'b0;
      done        = 1'b0;
      m.m_valid   = 1'b0;
      m.m_data    = '0;
      m.m_bit     = 1'b0;
      m.m_index   = '0;
      m.m_last    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = SEND;
            end
         end
         SEND: begin
            busy      = 1'b1;
            m.m_valid = 1'b1;
            m.m_data  = cur_clamp;
            m.m_bit   = cur_bit;
            m.m_index = idx;
            m.m_last  = at_last;
            if (m.m_ready && at_last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Capture happens only on an accepted start in IDLE; the snapshot is then
   // frozen until the next frame so upstream changes cannot leak into a stream.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx       <= '0;
         x_cap     <= '0;
         recon     <= '0;
         err_count <= '0;
         for (int i = 0; i < N_PIX; i++) begin
            prob_cap[i] <= ZERO_Q16;
         end
      end else if ((state == IDLE) && start) begin
         idx       <= '0;
         x_cap     <= x_in;
         recon     <= '0;
         err_count <= '0;
         for (int i = 0; i < N_PIX; i++) begin
            prob_cap[i] <= prob_in[i*DATA_W +: DATA_W];
         end
      end else if (beat_fire) begin
         recon[idx] <= cur_bit;
         err_count  <= err_count + IDX_W'(cur_bit ^ x_cap[idx]);
         if (!at_last) begin
            idx <= idx + IDX_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_recon_serializer.sv
// Bench for recon_serializer: table of directed frames, hand-written corner
// sequences and random frames checked against a per-pixel arithmetic model.
module tb_recon_serializer;
   import ae_pkg::*;

   typedef struct {
      logic [N_PIX-1:0]             x;
      logic [N_PIX-1:0][DATA_W-1:0] p;
      int                           mode;
      logic [N_PIX-1:0]             exp_recon;
      int                           exp_err;
   } vec_t;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    start;
   logic [N_PIX-1:0]        x_in;
   logic [N_PIX*DATA_W-1:0] prob_in;
   logic                    busy;
   logic [N_PIX-1:0]        recon;
   logic [IDX_W-1:0]        err_count;
   logic                    done;

   int checks = 0;
   int errors = 0;

   recon_serializer_if m ();

   recon_serializer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .x_in      (x_in),
      .prob_in   (prob_in),
      .busy      (busy),
      .m         (m),
      .recon     (recon),
      .err_count (err_count),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: saturate the signed value to [0, 65536] with plain integers.
   function automatic int clampModel(input logic [DATA_W-1:0] p);
      int v;
      v = int'($signed(p));
      if (v < 0) return 0;
      if (v > 65536) return 65536;
      return v;
   endfunction

   function automatic logic [DATA_W-1:0] pickProb();
      case ($urandom_range(0, 6))
         0: return 20'h10000;
         1: return 20'h08000;
         2: return 20'h07FFF;
         3: return 20'h10001;
         4: return 20'hFFFFF;
         5: return 20'h80000;
         default: return 20'($urandom);
      endcase
   endfunction

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_busy"}, 32'(busy), 0);
      checkOutput({tag, "_valid"}, 32'(m.m_valid), 0);
      checkOutput({tag, "_last"}, 32'(m.m_last), 0);
      checkOutput({tag, "_done"}, 32'(done), 0);
      checkOutput({tag, "_data"}, 32'(m.m_data), 0);
      checkOutput({tag, "_bit"}, 32'(m.m_bit), 0);
      checkOutput({tag, "_index"}, 32'(m.m_index), 0);
      checkOutput({tag, "_recon"}, 32'(recon), 0);
      checkOutput({tag, "_err"}, 32'(err_count), 0);
   endtask

   // mode: 0 ready always, 1 ready pattern 1,0,0,1, 2 random ready.
   // disturb: 1 start + input change at beat 4, 2 start during DONE.
   // abort_at >= 0 asserts rst (with start) once that many beats are accepted.
   task automatic applyStimulus(input logic [N_PIX-1:0] x, input logic [N_PIX-1:0][DATA_W-1:0] p,
                                input int mode, input int disturb, input int abort_at);
      logic [N_PIX-1:0] exp_recon;
      int               exp_err;
      int               idx;
      int               cyc;
      int               c;
      bit               finished;
      logic             rdy;
      exp_recon = '0;
      exp_err   = 0;
      idx       = 0;
      cyc       = 0;
      finished  = 1'b0;
      for (int i = 0; i < N_PIX; i++) begin
         exp_recon[i] = (clampModel(p[i]) >= 32768);
         exp_err     += int'(exp_recon[i] ^ x[i]);
      end
      @(negedge clk);
      x_in      = x;
      prob_in   = p;
      start     = 1'b1;
      m.m_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      while (!finished && cyc < 400) begin
         cyc++;
         if (abort_at >= 0 && idx == abort_at) begin
            m.m_ready = 1'b0;
            rst       = 1'b1;
            start     = 1'b1;
            @(negedge clk);
            #1;
            checkResetValues("abort");
            rst   = 1'b0;
            start = 1'b0;
            return;
         end
         case (mode)
            0: rdy = 1'b1;
            1: rdy = ((cyc % 4) == 1) || ((cyc % 4) == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         m.m_ready = rdy;
         if (disturb == 1 && idx == 4) begin
            start   = 1'b1;
            prob_in = ~p;
            x_in    = ~x;
         end else begin
            start   = 1'b0;
            prob_in = p;
            x_in    = x;
         end
         #1;
         c = clampModel(p[idx]);
         checkOutput("beat_valid", 32'(m.m_valid), 1);
         checkOutput("beat_busy", 32'(busy), 1);
         checkOutput("beat_index", 32'(m.m_index), 32'(idx));
         checkOutput("beat_data", 32'(m.m_data), 32'(c));
         checkOutput("beat_bit", 32'(m.m_bit), 32'(c >= 32768));
         checkOutput("beat_last", 32'(m.m_last), 32'(idx == N_PIX - 1));
         if (rdy) begin
            if (idx == N_PIX - 1) finished = 1'b1;
            idx++;
         end
         @(negedge clk);
      end
      if (!finished) begin
         checkOutput("stream_timeout", 32'(finished), 1);
      end
      m.m_ready = 1'($urandom_range(0, 1));
      start     = (disturb == 2);
      prob_in   = p;
      x_in      = x;
      #1;
      if (mode == 0) checkOutput("done_latency", 32'(cyc), 9);
      checkOutput("done_pulse", 32'(done), 1);
      checkOutput("done_busy", 32'(busy), 1);
      checkOutput("done_valid", 32'(m.m_valid), 0);
      checkOutput("done_recon", 32'(recon), 32'(exp_recon));
      checkOutput("done_err", 32'(err_count), 32'(exp_err));
      @(negedge clk);
      start     = 1'b0;
      m.m_ready = 1'b0;
      #1;
      checkOutput("idle_done", 32'(done), 0);
      checkOutput("idle_busy", 32'(busy), 0);
      checkOutput("idle_valid", 32'(m.m_valid), 0);
      checkOutput("hold_recon", 32'(recon), 32'(exp_recon));
      checkOutput("hold_err", 32'(err_count), 32'(exp_err));
   endtask

   vec_t tbl [4];
   logic [N_PIX-1:0][DATA_W-1:0] rp;

   initial begin
      tbl[0].x    = 9'b101010101;
      tbl[0].mode = 0;
      for (int i = 0; i < N_PIX; i++) tbl[0].p[i] = (i % 2 == 0) ? 20'h0F000 : 20'h01000;
      tbl[0].exp_recon = 9'b101010101;
      tbl[0].exp_err   = 0;

      tbl[1].x    = 9'b000000000;
      tbl[1].mode = 0;
      tbl[1].p[0] = 20'hFFF00;
      tbl[1].p[1] = 20'h12000;
      tbl[1].p[2] = 20'h08000;
      tbl[1].p[3] = 20'h07FFF;
      tbl[1].p[4] = 20'h10000;
      tbl[1].p[5] = 20'h00000;
      tbl[1].p[6] = 20'h80000;
      tbl[1].p[7] = 20'h7FFFF;
      tbl[1].p[8] = 20'h10001;
      tbl[1].exp_recon = 9'b110010110;
      tbl[1].exp_err   = 5;

      tbl[2].x    = 9'h1FF;
      tbl[2].mode = 1;
      for (int i = 0; i < N_PIX; i++) tbl[2].p[i] = 20'h00000;
      tbl[2].exp_recon = 9'h000;
      tbl[2].exp_err   = 9;

      tbl[3].x    = 9'h000;
      tbl[3].mode = 1;
      for (int i = 0; i < N_PIX; i++) tbl[3].p[i] = 20'h10000;
      tbl[3].exp_recon = 9'h1FF;
      tbl[3].exp_err   = 9;

      rst       = 1'b1;
      start     = 1'b0;
      x_in      = '0;
      prob_in   = '0;
      m.m_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checkResetValues("reset");
      rst = 1'b0;

      for (int v = 0; v < 4; v++) begin
         applyStimulus(tbl[v].x, tbl[v].p, tbl[v].mode, 0, -1);
         checkOutput($sformatf("tbl%0d_recon", v), 32'(recon), 32'(tbl[v].exp_recon));
         checkOutput($sformatf("tbl%0d_err", v), 32'(err_count), 32'(tbl[v].exp_err));
      end

      applyStimulus(tbl[1].x, tbl[1].p, 0, 1, -1);
      applyStimulus(tbl[0].x, tbl[0].p, 1, 1, -1);
      applyStimulus(tbl[2].x, tbl[1].p, 0, 2, -1);
      applyStimulus(tbl[3].x, tbl[1].p, 0, 0, -1);

      applyStimulus(tbl[0].x, tbl[1].p, 0, 0, 6);
      applyStimulus(tbl[2].x, tbl[0].p, 0, 0, -1);
      applyStimulus(tbl[0].x, tbl[1].p, 2, 0, 3);
      applyStimulus(tbl[0].x, tbl[0].p, 1, 0, -1);

      for (int f = 0; f < 40; f++) begin
         for (int i = 0; i < N_PIX; i++) rp[i] = pickProb();
         applyStimulus(9'($urandom), rp, 2, (f % 5 == 0) ? 1 : 0, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
